// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// ALU/PC-select encodings, the control vector and opcode classification helpers.
package cu_defs;

    typedef enum logic [2:0] {
        StIf    = 3'b000,
        StId    = 3'b001,
        StExeAl = 3'b010,
        StExeLs = 3'b011,
        StExeBr = 3'b100,
        StMem   = 3'b101,
        StWb    = 3'b110,
        StHalt  = 3'b111
    } state_e;

    localparam logic [5:0] OpAdd         = 6'b000000;
    localparam logic [5:0] OpSub         = 6'b000001;
    localparam logic [5:0] OpAnd         = 6'b010000;
    localparam logic [5:0] OpSlt         = 6'b100110;
    localparam logic [5:0] OpSll         = 6'b011000;
    localparam logic [5:0] OpAddiu       = 6'b000010;
    localparam logic [5:0] OpAndi        = 6'b010001;
    localparam logic [5:0] OpOri         = 6'b010010;
    localparam logic [5:0] OpSw          = 6'b110000;
    localparam logic [5:0] OpLw          = 6'b110001;
    localparam logic [5:0] OpBeq         = 6'b110100;
    localparam logic [5:0] OpBne         = 6'b110101;
    localparam logic [5:0] OpJ           = 6'b111000;
    localparam logic [5:0] OpHaltDefault = 6'b111111;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b100,
        AluSll = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        PcNext   = 2'b00,
        PcBranch = 2'b01,
        PcJump   = 2'b10
    } pc_src_e;

    typedef enum logic [2:0] {
        ClsAluR,
        ClsAluI,
        ClsLw,
        ClsSw,
        ClsBranch,
        ClsJump,
        ClsHalt,
        ClsUndef
    } op_class_e;

    typedef struct packed {
        logic    pc_wre;
        logic    ir_wre;
        pc_src_e pc_src;
        logic    reg_dst;
        logic    reg_wre;
        logic    db_data_src;
        logic    alu_src_a;
        logic    alu_src_b;
        logic    ext_sel;
        alu_op_e alu_op;
        logic    mem_rd;
        logic    mem_wr;
    } ctrl_t;

    // The halt opcode is a module parameter, so it overrides any other match.
    function automatic op_class_e op_class(input logic [5:0] op, input logic [5:0] halt_op);
        op_class_e cls;
        case (op)
            OpAdd, OpSub, OpAnd, OpSlt, OpSll: cls = ClsAluR;
            OpAddiu, OpAndi, OpOri:            cls = ClsAluI;
            OpLw:                              cls = ClsLw;
            OpSw:                              cls = ClsSw;
            OpBeq, OpBne:                      cls = ClsBranch;
            OpJ:                               cls = ClsJump;
            default:                           cls = ClsUndef;
        endcase
        if (op == halt_op) begin
            cls = ClsHalt;
        end
        return cls;
    endfunction

    function automatic alu_op_e alu_op_of(input logic [5:0] op);
        alu_op_e aop;
        case (op)
            OpSub, OpBeq, OpBne: aop = AluSub;
            OpAnd, OpAndi:       aop = AluAnd;
            OpOri:               aop = AluOr;
            OpSlt:               aop = AluSlt;
            OpSll:               aop = AluSll;
            default:             aop = AluAdd;
        endcase
        return aop;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bus between the control unit (master) and the CPU datapath (slave):
// opcode/zero flow in, every mux select and write enable flows out.
interface multicycle_control_unit_if;

    logic [5:0] Opcode;
    logic       zero;
    logic       PCWre;
    logic       IRWre;
    logic [1:0] PCSrc;
    logic       RegDst;
    logic       RegWre;
    logic       DBDataSrc;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       ExtSel;
    logic [2:0] ALUOp;
    logic       mRD;
    logic       mWR;

    modport master (
        input  Opcode, zero,
        output PCWre, IRWre, PCSrc, RegDst, RegWre, DBDataSrc,
               ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR
    );

    modport slave (
        output Opcode, zero,
        input  PCWre, IRWre, PCSrc, RegDst, RegWre, DBDataSrc,
               ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR
    );

endinterface

// File: rtl/multicycle_control_unit_decode.sv
// Combinational control decoder: maps (state, opcode, zero) to the datapath
// control vector. Holds no state.
module cu_decode
    import cu_defs::*;
#(
    parameter logic [5:0] HALT_OPCODE = OpHaltDefault
) (
    input  state_e     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    output ctrl_t      o_ctrl
);

    op_class_e w_cls;
    logic      w_taken;

    assign w_cls   = op_class(i_opcode, HALT_OPCODE);
    assign w_taken = ((i_opcode == OpBeq) &&  i_zero) ||
                     ((i_opcode == OpBne) && !i_zero);

    always_comb begin
        o_ctrl = '0;

        // Operand selects and ALUOp stay fixed from ID through MEM/WB so the
        // ALU result is still valid when the register file writes on negedge.
        if (i_state != StIf && i_state != StHalt) begin
            o_ctrl.reg_dst   = (w_cls == ClsAluR);
            o_ctrl.alu_src_a = (w_cls == ClsAluR) && (i_opcode == OpSll);
            o_ctrl.alu_src_b = (w_cls == ClsAluI) || (w_cls == ClsLw) || (w_cls == ClsSw);
            o_ctrl.ext_sel   = (i_opcode == OpAddiu) || (w_cls == ClsLw) ||
                               (w_cls == ClsSw) || (w_cls == ClsBranch);
            o_ctrl.alu_op    = alu_op_of(i_opcode);
        end

        case (i_state)
            StIf: begin
                o_ctrl.ir_wre = 1'b1;
            end
            StId: begin
                if (w_cls == ClsJump) begin
                    o_ctrl.pc_wre = 1'b1;
                    o_ctrl.pc_src = PcJump;
                end else if (w_cls == ClsUndef) begin
                    o_ctrl.pc_wre = 1'b1;
                end
            end
            StExeBr: begin
                o_ctrl.pc_wre = 1'b1;
                o_ctrl.alu_op = AluSub;
                if (w_taken) begin
                    o_ctrl.pc_src = PcBranch;
                end
            end
            StMem: begin
                o_ctrl.mem_rd = (w_cls == ClsLw);
                o_ctrl.mem_wr = (w_cls == ClsSw);
                o_ctrl.pc_wre = (w_cls != ClsLw);
            end
            StWb: begin
                o_ctrl.reg_wre     = 1'b1;
                o_ctrl.pc_wre      = 1'b1;
                o_ctrl.db_data_src = (w_cls == ClsLw);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU controller: state register and next-state sequencing; all
// control outputs come combinationally from the decoder.
module multicycle_control_unit
    import cu_defs::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic                             CLK,
    input  logic                             Reset,
    multicycle_control_unit_if.master        bus,
    output logic [2:0]                       state_o
);

    state_e    r_state;
    state_e    w_state_next;
    op_class_e w_cls;
    ctrl_t     w_ctrl;

    assign w_cls = op_class(bus.Opcode, HALT_OPCODE);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= StIf;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIf: w_state_next = StId;
            StId: begin
                case (w_cls)
                    ClsAluR, ClsAluI: w_state_next = StExeAl;
                    ClsLw, ClsSw:     w_state_next = StExeLs;
                    ClsBranch:        w_state_next = StExeBr;
                    ClsHalt:          w_state_next = StHalt;
                    default:          w_state_next = StIf;
                endcase
            end
            StExeAl: w_state_next = StWb;
            StExeLs: w_state_next = StMem;
            StExeBr: w_state_next = StIf;
            StMem:   w_state_next = (w_cls == ClsLw) ? StWb : StIf;
            StWb:    w_state_next = StIf;
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StIf;
        endcase
    end

    cu_decode #(
        .HALT_OPCODE (HALT_OPCODE)
    ) u_decode (
        .i_state  (r_state),
        .i_opcode (bus.Opcode),
        .i_zero   (bus.zero),
        .o_ctrl   (w_ctrl)
    );

    assign bus.PCWre     = w_ctrl.pc_wre;
    assign bus.IRWre     = w_ctrl.ir_wre;
    assign bus.PCSrc     = w_ctrl.pc_src;
    assign bus.RegDst    = w_ctrl.reg_dst;
    assign bus.RegWre    = w_ctrl.reg_wre;
    assign bus.DBDataSrc = w_ctrl.db_data_src;
    assign bus.ALUSrcA   = w_ctrl.alu_src_a;
    assign bus.ALUSrcB   = w_ctrl.alu_src_b;
    assign bus.ExtSel    = w_ctrl.ext_sel;
    assign bus.ALUOp     = w_ctrl.alu_op;
    assign bus.mRD       = w_ctrl.mem_rd;
    assign bus.mWR       = w_ctrl.mem_wr;
    assign state_o       = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus queues the expected
// per-cycle control vector, a negedge monitor pops and compares it.
module tb_multicycle_control_unit;

    // Vector layout: {state[2:0], PCWre, IRWre, PCSrc[1:0], RegDst, RegWre,
    //                 DBDataSrc, ALUSrcA, ALUSrcB, ExtSel, ALUOp[2:0], mRD, mWR}
    localparam logic [17:0] V_IF       = 18'b000_0_1_00_0_0_0_0_0_0_000_0_0;
    localparam logic [17:0] V_ADD_ID   = 18'b001_0_0_00_1_0_0_0_0_0_000_0_0;
    localparam logic [17:0] V_ADD_EXE  = 18'b010_0_0_00_1_0_0_0_0_0_000_0_0;
    localparam logic [17:0] V_ADD_WB   = 18'b110_1_0_00_1_1_0_0_0_0_000_0_0;
    localparam logic [17:0] V_LW_ID    = 18'b001_0_0_00_0_0_0_0_1_1_000_0_0;
    localparam logic [17:0] V_LW_EXE   = 18'b011_0_0_00_0_0_0_0_1_1_000_0_0;
    localparam logic [17:0] V_LW_MEM   = 18'b101_0_0_00_0_0_0_0_1_1_000_1_0;
    localparam logic [17:0] V_LW_WB    = 18'b110_1_0_00_0_1_1_0_1_1_000_0_0;
    localparam logic [17:0] V_BR_ID    = 18'b001_0_0_00_0_0_0_0_0_1_001_0_0;
    localparam logic [17:0] V_BR_TAKE  = 18'b100_1_0_01_0_0_0_0_0_1_001_0_0;
    localparam logic [17:0] V_BR_NOT   = 18'b100_1_0_00_0_0_0_0_0_1_001_0_0;
    localparam logic [17:0] V_J_ID     = 18'b001_1_0_10_0_0_0_0_0_0_000_0_0;
    localparam logic [17:0] V_SW_ID    = 18'b001_0_0_00_0_0_0_0_1_1_000_0_0;
    localparam logic [17:0] V_SW_EXE   = 18'b011_0_0_00_0_0_0_0_1_1_000_0_0;
    localparam logic [17:0] V_SW_MEM   = 18'b101_1_0_00_0_0_0_0_1_1_000_0_1;
    localparam logic [17:0] V_ORI_ID   = 18'b001_0_0_00_0_0_0_0_1_0_011_0_0;
    localparam logic [17:0] V_ORI_EXE  = 18'b010_0_0_00_0_0_0_0_1_0_011_0_0;
    localparam logic [17:0] V_ORI_WB   = 18'b110_1_0_00_0_1_0_0_1_0_011_0_0;
    localparam logic [17:0] V_SLL_ID   = 18'b001_0_0_00_1_0_0_1_0_0_101_0_0;
    localparam logic [17:0] V_SLL_EXE  = 18'b010_0_0_00_1_0_0_1_0_0_101_0_0;
    localparam logic [17:0] V_SLL_WB   = 18'b110_1_0_00_1_1_0_1_0_0_101_0_0;
    localparam logic [17:0] V_UND_ID   = 18'b001_1_0_00_0_0_0_0_0_0_000_0_0;
    localparam logic [17:0] V_HALT_ID  = 18'b001_0_0_00_0_0_0_0_0_0_000_0_0;
    localparam logic [17:0] V_HALT     = 18'b111_0_0_00_0_0_0_0_0_0_000_0_0;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_UND  = 6'b000111;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef struct {
        string       name;
        logic [17:0] vec;
    } exp_t;

    logic       CLK;
    logic       Reset;
    logic [2:0] state_o;
    int         errors;
    int         checks;
    exp_t       exp_q[$];

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(
        .HALT_OPCODE (6'b111111)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .bus     (bus),
        .state_o (state_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [17:0] act;
            e   = exp_q.pop_front();
            act = {state_o, bus.PCWre, bus.IRWre, bus.PCSrc, bus.RegDst, bus.RegWre,
                   bus.DBDataSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel, bus.ALUOp,
                   bus.mRD, bus.mWR};
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.vec);
            end
        end
    end

    // Present one cycle's inputs and expected outputs, then advance past the edge.
    task automatic cyc(input string nm, input logic [5:0] op, input logic z,
                       input logic [17:0] v);
        exp_t e;
        bus.Opcode = op;
        bus.zero   = z;
        e.name     = nm;
        e.vec      = v;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        Reset      = 1'b0;
        bus.Opcode = OP_ADD;
        bus.zero   = 1'b0;
        @(posedge CLK);
        #1;
        cyc("reset_hold", OP_ADD, 1'b0, V_IF);
        Reset = 1'b1;

        // add, aborted in WB by an asynchronous reset
        cyc("abort_if", OP_ADD, 1'b0, V_IF);
        cyc("abort_id", OP_ADD, 1'b0, V_ADD_ID);
        cyc("abort_exe", OP_ADD, 1'b0, V_ADD_EXE);
        Reset = 1'b0;
        cyc("abort_rst", OP_ADD, 1'b0, V_IF);
        Reset = 1'b1;

        cyc("add_if", OP_ADD, 1'b0, V_IF);
        cyc("add_id", OP_ADD, 1'b0, V_ADD_ID);
        cyc("add_exe", OP_ADD, 1'b0, V_ADD_EXE);
        cyc("add_wb", OP_ADD, 1'b0, V_ADD_WB);

        cyc("lw_if", OP_LW, 1'b0, V_IF);
        cyc("lw_id", OP_LW, 1'b0, V_LW_ID);
        cyc("lw_exe", OP_LW, 1'b0, V_LW_EXE);
        cyc("lw_mem", OP_LW, 1'b0, V_LW_MEM);
        cyc("lw_wb", OP_LW, 1'b0, V_LW_WB);

        cyc("beq1_if", OP_BEQ, 1'b1, V_IF);
        cyc("beq1_id", OP_BEQ, 1'b1, V_BR_ID);
        cyc("beq1_exe", OP_BEQ, 1'b1, V_BR_TAKE);
        cyc("beq0_if", OP_BEQ, 1'b0, V_IF);
        cyc("beq0_id", OP_BEQ, 1'b0, V_BR_ID);
        cyc("beq0_exe", OP_BEQ, 1'b0, V_BR_NOT);
        cyc("bne1_if", OP_BNE, 1'b1, V_IF);
        cyc("bne1_id", OP_BNE, 1'b1, V_BR_ID);
        cyc("bne1_exe", OP_BNE, 1'b1, V_BR_NOT);
        cyc("bne0_if", OP_BNE, 1'b0, V_IF);
        cyc("bne0_id", OP_BNE, 1'b0, V_BR_ID);
        cyc("bne0_exe", OP_BNE, 1'b0, V_BR_TAKE);

        cyc("j_if", OP_J, 1'b0, V_IF);
        cyc("j_id", OP_J, 1'b0, V_J_ID);
        cyc("sw_if", OP_SW, 1'b0, V_IF);
        cyc("sw_id", OP_SW, 1'b0, V_SW_ID);
        cyc("sw_exe", OP_SW, 1'b0, V_SW_EXE);
        cyc("sw_mem", OP_SW, 1'b0, V_SW_MEM);
        cyc("ori_if", OP_ORI, 1'b0, V_IF);
        cyc("ori_id", OP_ORI, 1'b0, V_ORI_ID);
        cyc("ori_exe", OP_ORI, 1'b0, V_ORI_EXE);
        cyc("ori_wb", OP_ORI, 1'b0, V_ORI_WB);

        cyc("sll_if", OP_SLL, 1'b0, V_IF);
        cyc("sll_id", OP_SLL, 1'b0, V_SLL_ID);
        cyc("sll_exe", OP_SLL, 1'b0, V_SLL_EXE);
        cyc("sll_wb", OP_SLL, 1'b0, V_SLL_WB);

        cyc("und_if", OP_UND, 1'b0, V_IF);
        cyc("und_id", OP_UND, 1'b0, V_UND_ID);

        cyc("halt_if", OP_HALT, 1'b0, V_IF);
        cyc("halt_id", OP_HALT, 1'b0, V_HALT_ID);
        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("halt_hold_%0d", i), OP_HALT, 1'b0, V_HALT);
        end
        Reset = 1'b0;
        cyc("halt_rst", OP_ADD, 1'b0, V_IF);
        Reset = 1'b1;
        cyc("post_if", OP_ADD, 1'b0, V_IF);
        cyc("post_id", OP_ADD, 1'b0, V_ADD_ID);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge CLK);
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle FSM controller that sequences the CPU datapath: PC, instruction register, register file, ALU and data memory.
- Decodes the 6-bit opcode latched in the IR and steps each instruction through IF/ID/EXE/MEM/WB.
- Drives the register-file controls RegDst, RegWre and DBDataSrc so a register write occurs only in a WB state.
- Sits between the IR and every datapath mux/write-enable; the datapath itself stays purely structural.

Parameters:
- HALT_OPCODE, 6'b111111, opcode that parks the FSM in HALT.

Ports:
- CLK  input  1  system clock; state updates on posedge (register file writes on negedge).
- Reset  input  1  asynchronous, active-low reset.
- Opcode  input  6  IR[31:26]; valid from ID onward.
- zero  input  1  ALU zero flag, sampled in EXE_BR.
- PCWre  output  1  PC load enable.
- IRWre  output  1  IR load enable.
- PCSrc  output  2  00 PC+4, 01 branch target, 10 jump target.
- RegDst  output  1  1 selects rd, 0 selects rt.
- RegWre  output  1  register file write enable.
- DBDataSrc  output  1  0 ALU result, 1 memory data.
- ALUSrcA  output  1  1 selects shamt (sll only).
- ALUSrcB  output  1  1 selects extended immediate.
- ExtSel  output  1  1 sign-extend, 0 zero-extend.
- ALUOp  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 sll.
- mRD  output  1  data memory read.
- mWR  output  1  data memory write.
- state_o  output  3  current state, for debug.

Behaviour:
- Reset (async, Reset=0): state=IF. All outputs are 0 except IRWre=1 (the IF decode); PCSrc=00 and ALUOp=000.
- States: IF=000, ID=001, EXE_AL=010, EXE_LS=011, EXE_BR=100, MEM=101, WB=110, HALT=111.
- Opcode groups:
  - ALU-R: add 000000, sub 000001, and 010000, slt 100110, sll 011000.
  - ALU-I: addiu 000010, andi 010001, ori 010010.
  - sw 110000, lw 110001, beq 110100, bne 110101, j 111000, halt = HALT_OPCODE.
- State sequences:
  - ALU-R / ALU-I: IF→ID→EXE_AL→WB→IF (4 cycles).
  - lw: IF→ID→EXE_LS→MEM→WB→IF (5 cycles).
  - sw: IF→ID→EXE_LS→MEM→IF (4 cycles).
  - beq/bne: IF→ID→EXE_BR→IF (3 cycles).
  - j: IF→ID→IF (2 cycles).
  - halt: IF→ID→HALT; holds until Reset.
  - Undefined opcode: ID→IF with PCWre=1, PCSrc=00 (executes as NOP).
- Outputs are combinational from (state, Opcode); no output registers.
- IRWre=1 only in IF.
- PCWre=1 for exactly one cycle per instruction, in its last state. The only states that can assert it are WB, MEM (sw), EXE_BR, ID (j/undefined). HALT keeps PCWre=0.
- RegWre=1 only in WB. RegDst=1 only for ALU-R. DBDataSrc=1 only for lw in WB.
- mRD=1 in MEM for lw; mWR=1 in MEM for sw; never both at once.
- ALUSrcB=1 for ALU-I, lw and sw. ALUSrcA=1 only for sll.
- ExtSel=1 for addiu, lw, sw, beq, bne; 0 for andi/ori.
- ALUOp is held stable across EXE and the following MEM/WB, so the ALU result stays valid at the negedge write.
- EXE_BR: ALUOp=sub. PCSrc=01 if (beq&zero) or (bne&!zero), else 00.
- ID with j: PCSrc=10.
- A reset assertion mid-instruction abandons it immediately; no partial register or memory write survives into the next cycle.

Decomposition:
- Shared package cu_defs holds: opcode localparams, state encodings, ALUOp and PCSrc encodings.
- One sub-module, cu_decode: combinational map from (state, Opcode, zero) to the control vector.
- The top module holds only the state register and next-state logic.

Test Plan:
- Reset low mid-EXE_AL, then release → state_o=000, IRWre=1, RegWre=0, PCWre=0 on the first cycle after release.
- add (000000) → 4 cycles. WB: RegWre=1, RegDst=1, DBDataSrc=0, PCWre=1. No other cycle has RegWre=1.
- lw (110001) → 5 cycles. MEM: mRD=1. WB: DBDataSrc=1, RegDst=0, ALUSrcB=1, ExtSel=1.
- beq with zero=1 → EXE_BR: PCSrc=01, PCWre=1. With zero=0 → PCSrc=00. Repeat for bne with the outcome inverted.
- Back-to-back j, sw, ori → exactly one PCWre pulse each. sw: mWR=1 only in MEM, RegWre=0 throughout. ori: ExtSel=0.
- Opcode 111111 → HALT reached, then hold 20 cycles: PCWre=0, IRWre=0, state_o=111. Pulse Reset low → IF.
